// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/bubble/flush/freeze sequencer with EX/MEM scoreboard
// Optional forwarding mode: define PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
  parameter int REGW = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_D,
  input  logic [REGW-1:0] rs_D,
  input  logic            rs_used_D,
  input  logic [REGW-1:0] rt_D,
  input  logic            rt_used_D,
  input  logic            wr_en_D,
  input  logic [REGW-1:0] wr_reg_D,
  input  logic            mem_read_D,
  input  logic            halt_D,
  input  logic            taken_EX,
  input  logic            dmem_stall,
  output logic            stall_F,
  output logic            bubble_DX,
  output logic            flush_FD,
  output logic            flush_DX,
  output logic            freeze,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt
`ifdef PIPE_HAZARD_FWD_EN
  ,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`endif
);

  typedef enum logic [1:0] {S_RUN, S_HAZ, S_MWAIT, S_HALT} state_t;

  state_t          state, next_state;
  logic            ex_v, ex_ld, mem_v, mem_ld;
  logic [REGW-1:0] ex_reg, mem_reg;
  logic            hit_ex, hit_mem, hazard, issue, halt_st;
  logic            unused_ld;

  assign hit_ex  = ex_v  & ((rs_used_D & (rs_D == ex_reg))  | (rt_used_D & (rt_D == ex_reg)));
  assign hit_mem = mem_v & ((rs_used_D & (rs_D == mem_reg)) | (rt_used_D & (rt_D == mem_reg)));

`ifdef PIPE_HAZARD_FWD_EN
  assign hazard = valid_D & hit_ex & ex_ld;
`else
  assign hazard = valid_D & (hit_ex | hit_mem);
`endif

  assign halt_st   = (state == S_HALT);
  assign issue     = valid_D & ~hazard & ~taken_EX & ~halt_st;
  assign unused_ld = mem_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= next_state;
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  always_comb begin
    next_state = state;
    stall_F    = 1'b0;
    bubble_DX  = 1'b0;
    flush_FD   = 1'b0;
    flush_DX   = 1'b0;
    freeze     = 1'b0;
    halted     = 1'b0;
    if (halt_st) begin
      halted    = 1'b1;
      stall_F   = 1'b1;
      freeze    = dmem_stall;
      bubble_DX = ~dmem_stall;
    end else if (dmem_stall) begin
      freeze     = 1'b1;
      stall_F    = 1'b1;
      next_state = S_MWAIT;
    end else if (taken_EX) begin
      flush_FD   = 1'b1;
      flush_DX   = 1'b1;
      next_state = S_RUN;
    end else if (hazard) begin
      stall_F    = 1'b1;
      bubble_DX  = 1'b1;
      next_state = S_HAZ;
    end else begin
      next_state = (valid_D & halt_D) ? S_HALT : S_RUN;
    end
    if (rst) begin
      stall_F   = 1'b0;
      bubble_DX = 1'b0;
      flush_FD  = 1'b0;
      flush_DX  = 1'b0;
      freeze    = 1'b0;
      halted    = 1'b0;
    end
  end

  // Scoreboard advances unless memory is busy; WB writes are bypassed by the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v    <= 1'b0;
      ex_reg  <= '0;
      ex_ld   <= 1'b0;
      mem_v   <= 1'b0;
      mem_reg <= '0;
      mem_ld  <= 1'b0;
    end else if (!dmem_stall) begin
      ex_v    <= issue & wr_en_D;
      ex_reg  <= wr_reg_D;
      ex_ld   <= mem_read_D;
      mem_v   <= ex_v;
      mem_reg <= ex_reg;
      mem_ld  <= ex_ld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_F && !halt_st && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

`ifdef PIPE_HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic used, input logic [REGW-1:0] src);
    if (used && ex_v && src == ex_reg)        return 2'b01;
    else if (used && mem_v && src == mem_reg) return 2'b10;
    else                                      return 2'b00;
  endfunction

  // Select travels into EX with the instruction; EX wins on a double match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (!dmem_stall) begin
      fwd_a <= issue ? fwd_sel(rs_used_D, rs_D) : 2'b00;
      fwd_b <= issue ? fwd_sel(rt_used_D, rt_D) : 2'b00;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random self-check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_D = 0, rs_used_D = 0, rt_used_D = 0, wr_en_D = 0, mem_read_D = 0, halt_D = 0;
  logic taken_EX = 0, dmem_stall = 0;
  logic [2:0] rs_D = 0, rt_D = 0, wr_reg_D = 0;
  logic stall_F, bubble_DX, flush_FD, flush_DX, freeze, halted;
  logic [CW-1:0] stall_cnt;
`ifdef PIPE_HAZARD_FWD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(3), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .rs_D(rs_D), .rs_used_D(rs_used_D),
    .rt_D(rt_D), .rt_used_D(rt_used_D), .wr_en_D(wr_en_D), .wr_reg_D(wr_reg_D),
    .mem_read_D(mem_read_D), .halt_D(halt_D), .taken_EX(taken_EX), .dmem_stall(dmem_stall),
    .stall_F(stall_F), .bubble_DX(bubble_DX), .flush_FD(flush_FD), .flush_DX(flush_DX),
    .freeze(freeze), .halted(halted), .stall_cnt(stall_cnt)
`ifdef PIPE_HAZARD_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  int total = 0;
  int bad = 0;

  // Reference: list of in-flight writers, index 0 = just issued, 1 = one stage older.
  typedef struct {bit v; bit [2:0] r;} ent_t;
  ent_t inflight[2];
  bit   m_halt;
  int   m_cnt;
  bit   e_stall, e_bub, e_ffd, e_fdx, e_frz, e_halted, m_issue;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input ent_t e);
    return e.v && ((rs_used_D && rs_D == e.r) || (rt_used_D && rt_D == e.r));
  endfunction

  task automatic model_reset();
    inflight[0] = '{0, 0};
    inflight[1] = '{0, 0};
    m_halt = 0;
    m_cnt  = 0;
  endtask

  task automatic model_outputs();
    bit dep;
    dep = valid_D && (reads(inflight[0]) || reads(inflight[1]));
    {e_stall, e_bub, e_ffd, e_fdx, e_frz, e_halted, m_issue} = '0;
    if (m_halt) begin
      e_halted = 1; e_stall = 1; e_frz = dmem_stall; e_bub = !dmem_stall;
    end else if (dmem_stall) begin
      e_frz = 1; e_stall = 1;
    end else if (taken_EX) begin
      e_ffd = 1; e_fdx = 1;
    end else if (dep) begin
      e_stall = 1; e_bub = 1;
    end else begin
      m_issue = valid_D;
    end
  endtask

  task automatic model_update();
    if (e_stall && !m_halt) m_cnt = (m_cnt >= MAX) ? MAX : m_cnt + 1;
    if (!dmem_stall) begin
      inflight[1] = inflight[0];
      inflight[0] = '{m_issue && wr_en_D, wr_reg_D};
    end
    if (m_issue && halt_D) m_halt = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_outputs();
    check("stall_F", stall_F, e_stall);
    check("bubble_DX", bubble_DX, e_bub);
    check("flush_FD", flush_FD, e_ffd);
    check("flush_DX", flush_DX, e_fdx);
    check("freeze", freeze, e_frz);
    check("halted", halted, e_halted);
    check("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic instr(input bit v, input bit [2:0] rs, input bit rsu, input bit [2:0] rt,
                       input bit rtu, input bit wr, input bit [2:0] wd, input bit ld, input bit hl);
    valid_D = v; rs_D = rs; rs_used_D = rsu; rt_D = rt; rt_used_D = rtu;
    wr_en_D = wr; wr_reg_D = wd; mem_read_D = ld; halt_D = hl;
    taken_EX = 0; dmem_stall = 0;
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    nop();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    nop();
    #2;
    check("rst_stall_F", stall_F, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", stall_cnt, 0);
    do_reset();

    // Back-to-back RAW on r3: two stall cycles, then issue.
    instr(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
    instr(1, 3, 1, 1, 1, 1, 4, 0, 0); cycle(); cycle(); cycle();
    check("raw_cnt", stall_cnt, 2);
    nop(); cycle(); cycle();

    // Taken branch with coincident hazard: squash, no scoreboard entry.
    instr(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    instr(1, 2, 0, 5, 1, 1, 6, 0, 0); taken_EX = 1; cycle();
    instr(1, 2, 0, 5, 1, 1, 6, 0, 0); cycle(); cycle();
    nop(); cycle(); cycle();

    // Memory wait in the middle of a pending hazard.
    instr(1, 0, 0, 0, 0, 1, 4, 1, 0); cycle();
    instr(1, 4, 1, 0, 0, 1, 7, 0, 0); cycle();
    dmem_stall = 1; cycle(); cycle(); cycle();
    dmem_stall = 0; cycle(); cycle();
    nop(); cycle(); cycle();

    // Halt with two older writes in flight.
    instr(1, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    instr(1, 0, 0, 0, 0, 1, 2, 0, 0); cycle();
    instr(1, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    check("halt_now", halted, 1);
    instr(1, 1, 1, 2, 1, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("halt_hold", halted, 1);

    // Reset while a hazard is being held.
    do_reset();
    instr(1, 0, 0, 0, 0, 1, 6, 0, 0); cycle();
    instr(1, 6, 1, 0, 0, 0, 0, 0, 0); cycle();
    rst = 1;
    #2;
    check("midrst_stall_F", stall_F, 0);
    check("midrst_bubble", bubble_DX, 0);
    check("midrst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    cycle();
    nop(); cycle();

    // Counter saturation.
    do_reset();
    dmem_stall = 1;
    for (int i = 0; i < MAX + 5; i++) cycle();
    check("sat_cnt", stall_cnt, MAX);

    // Randomized traffic against the reference.
    for (int run = 0; run < 4; run++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        instr(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 3)), 1'($urandom),
              3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 63) == 0));
        taken_EX   = ($urandom_range(0, 9) == 0);
        dmem_stall = ($urandom_range(0, 6) == 0);
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
